inst_sram_responder: RTL and testbench
======================================

Name: inst_sram_responder

Overview:
- Memory-side responder for the 1-cycle synchronous inst SRAM interface that the IF stage drives with en/wen/addr/wdata and samples as rdata.
- Holds a word-organised array and applies per-byte writes.
- Returns read data exactly one cycle after an enabled access.
- Translates kseg0/kseg1 virtual addresses to array indices, flags out-of-range accesses, and keeps access counters for debug.

Parameters:
- AW, 14, log2 of array depth in 32-bit words; the array holds 2^AW words.
- BASE_PADDR, 32'h1fc00000, physical byte address of word 0; must be word-aligned.

Ports:
- clk  in  1  clock; all sampling on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_sram_en  in  1  access request this cycle.
- inst_sram_wen  in  4  byte write enables; bit i writes wdata[8i+7:8i]; 4'h0 means read.
- inst_sram_addr  in  32  byte address (virtual).
- inst_sram_wdata  in  32  write data.
- inst_sram_rdata  out  32  registered read data.
- err_valid  out  1  sticky flag: an out-of-range access has occurred.
- err_addr  out  32  virtual address of the first out-of-range access.
- rd_cnt  out  32  count of accepted read accesses.
- wr_cnt  out  32  count of accepted write accesses.

Behaviour:
- Reset (asynchronous, active-high) forces these values immediately:
  - inst_sram_rdata=0, err_valid=0, err_addr=0, rd_cnt=0, wr_cnt=0.
  - Array contents are not reset.
- Address translation, combinational:
  - paddr = {3'b000, addr[28:0]}, i.e. kseg0 and kseg1 both fold onto physical space.
  - off = paddr − BASE_PADDR, 32-bit unsigned wrap.
  - In range when off < 4·2^AW; word index = off[AW+1:2].
  - addr[1:0] are ignored; accesses are word-aligned.
- Access in cycle T with en=1 and wen=0 (read), in range:
  - rdata at T+1 = array[index] as sampled at edge T.
  - rd_cnt increments by 1.
- Access in cycle T with en=1 and wen≠0 (write), in range:
  - Only the enabled bytes of array[index] update at edge T.
  - rdata at T+1 = the old full word (read-first semantics).
  - wr_cnt increments by 1.
- Access with en=1, out of range:
  - No array write.
  - rdata at T+1 = 32'h0.
  - The counter for the access type still increments.
  - If err_valid=0: err_valid←1 and err_addr←addr. Later errors leave err_addr unchanged; only reset clears it.
- en=0:
  - rdata holds its previous value indefinitely, matching SRAM output-register behaviour that the fetch stage relies on when stalled.
  - No counter change.
- Back-to-back accesses:
  - One access is accepted every cycle; there is no busy state and no backpressure.
  - A read of address A in cycle T+1 after a write to A in cycle T returns the new data at T+2.
- Counters wrap from 32'hffffffff to 0.
- Reset asserted mid-access: the in-flight read result is discarded and rdata reads 0 immediately.
- Array write while reset is high: none, regardless of en.

Test Plan:
- Reset then en=1, wen=0, addr=32'hbfc00000 (array[0]=32'h3c1d0000) → rdata=32'h3c1d0000 on the next cycle; rd_cnt=1.
- Write wen=4'b0011, wdata=32'haabbccdd to 32'h9fc00004 (old word 32'h11223344), then read 32'hbfc00004 → write-cycle rdata=32'h11223344; read returns 32'h1122ccdd; wr_cnt=1, rd_cnt=1.
- Read 32'hbfc00008, then hold en=0 for 5 cycles → rdata stays equal to array[2] for all 5 cycles; counters unchanged.
- Read 32'hbfc00000+4·2^AW, then read 32'h00000000 → rdata=0 both times; err_valid=1; err_addr=32'hbfc00000+4·2^AW (first error kept).
- Reads on consecutive cycles to addresses 0xbfc00000, 0xbfc00004, 0xbfc00008 → rdata is array[0], array[1], array[2] on successive cycles with no gaps.
- Assert reset asynchronously between clock edges while a read is in flight → rdata, counters and err_valid are 0 before the next edge; reads after reset deassertion still return array contents written before reset.

Source files
------------

// File: rtl/inst_sram_responder.sv
// inst_sram_responder: 1-cycle synchronous inst SRAM model with kseg folding, range check and access counters
module inst_sram_responder #(
  parameter int          AW         = 14,
  parameter logic [31:0] BASE_PADDR = 32'h1fc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        err_valid,
  output logic [31:0] err_addr,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);
  localparam logic [31:0] SPAN = 32'd4 << AW;
  logic [31:0] mem [2**AW];
  logic [31:0] paddr, off;
  logic [AW-1:0] idx;
  logic in_range, do_wr;
  assign paddr    = {3'b000, inst_sram_addr[28:0]};
  assign off      = paddr - BASE_PADDR;
  assign in_range = off < SPAN;
  assign idx      = off[AW+1:2];
  assign do_wr    = inst_sram_en && in_range && !reset;
  // byte-masked array write; contents survive reset but no write lands while reset is high
  always_ff @(posedge clk) begin
    if (do_wr)
      for (int i = 0; i < 4; i++)
        if (inst_sram_wen[i]) mem[idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
  end
  // read-first output register; holds its value while en is low, zero for out-of-range
  always_ff @(posedge clk or posedge reset) begin
    if (reset) inst_sram_rdata <= '0;
    else if (inst_sram_en) inst_sram_rdata <= in_range ? mem[idx] : '0;
  end
  // access counters and sticky first-error capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (inst_sram_en) begin
      if (|inst_sram_wen) wr_cnt <= wr_cnt + 32'd1;
      else rd_cnt <= rd_cnt + 32'd1;
      if (!in_range && !err_valid) begin
        err_valid <= 1'b1;
        err_addr  <= inst_sram_addr;
      end
    end
  end
endmodule

// File: tb/tb_inst_sram_responder.sv
// tb_inst_sram_responder: directed checks of read/write, hold, range errors, back-to-back and async reset
module tb_inst_sram_responder;
  logic        clk = 0;
  logic        reset = 1;
  logic        en = 0;
  logic [3:0]  wen = 0;
  logic [31:0] addr = 0;
  logic [31:0] wdata = 0;
  logic [31:0] rdata, err_addr, rd_cnt, wr_cnt;
  logic        err_valid;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rd = 0;
  logic [31:0] exp_wr = 0;

  inst_sram_responder dut (
    .clk(clk), .reset(reset), .inst_sram_en(en), .inst_sram_wen(wen),
    .inst_sram_addr(addr), .inst_sram_wdata(wdata), .inst_sram_rdata(rdata),
    .err_valid(err_valid), .err_addr(err_addr), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic acc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdata !== 32'h0 || err_valid !== 1'b0 || err_addr !== 32'h0 || rd_cnt !== 32'h0 || wr_cnt !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: rdata=%h err=%b err_addr=%h rd=%0d wr=%0d, want all zero", rdata, err_valid, err_addr, rd_cnt, wr_cnt);
    end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_read();
    acc(1, 4'hf, 32'hbfc00000, 32'h3c1d0000);
    acc(1, 4'hf, 32'hbfc00004, 32'h11223344);
    acc(1, 4'hf, 32'hbfc00008, 32'hdeadbeef);
    exp_wr = 3;
    acc(1, 4'h0, 32'hbfc00000, 32'h0);
    exp_rd = 1;
    checks++;
    if (rdata !== 32'h3c1d0000) begin
      failures++;
      $display("FAIL read_word0: got %h want %h", rdata, 32'h3c1d0000);
    end
    checks++;
    if (rd_cnt !== exp_rd || wr_cnt !== exp_wr) begin
      failures++;
      $display("FAIL read_counts: rd=%0d wr=%0d want rd=%0d wr=%0d", rd_cnt, wr_cnt, exp_rd, exp_wr);
    end
  endtask

  task automatic test_byte_write();
    acc(1, 4'b0011, 32'h9fc00004, 32'haabbccdd);
    exp_wr++;
    checks++;
    if (rdata !== 32'h11223344) begin
      failures++;
      $display("FAIL write_read_first: got %h want %h", rdata, 32'h11223344);
    end
    acc(1, 4'h0, 32'hbfc00004, 32'h0);
    exp_rd++;
    checks++;
    if (rdata !== 32'h1122ccdd) begin
      failures++;
      $display("FAIL byte_merge: got %h want %h", rdata, 32'h1122ccdd);
    end
    checks++;
    if (rd_cnt !== exp_rd || wr_cnt !== exp_wr) begin
      failures++;
      $display("FAIL write_counts: rd=%0d wr=%0d want rd=%0d wr=%0d", rd_cnt, wr_cnt, exp_rd, exp_wr);
    end
  endtask

  task automatic test_hold();
    acc(1, 4'h0, 32'hbfc00008, 32'h0);
    exp_rd++;
    for (int i = 0; i < 5; i++) begin
      acc(0, 4'hf, 32'hbfc00000, 32'h55555555);
      checks++;
      if (rdata !== 32'hdeadbeef || rd_cnt !== exp_rd || wr_cnt !== exp_wr) begin
        failures++;
        $display("FAIL hold_cycle%0d: rdata=%h rd=%0d wr=%0d want %h rd=%0d wr=%0d", i, rdata, rd_cnt, wr_cnt, 32'hdeadbeef, exp_rd, exp_wr);
      end
    end
    acc(1, 4'h0, 32'hbfc00000, 32'h0);
    exp_rd++;
    checks++;
    if (rdata !== 32'h3c1d0000) begin
      failures++;
      $display("FAIL hold_no_write: got %h want %h", rdata, 32'h3c1d0000);
    end
  endtask

  task automatic test_boundary();
    acc(1, 4'hf, 32'hbfc0fffc, 32'h0badf00d);
    exp_wr++;
    acc(1, 4'h0, 32'h9fc0fffc, 32'h0);
    exp_rd++;
    checks++;
    if (rdata !== 32'h0badf00d || err_valid !== 1'b0) begin
      failures++;
      $display("FAIL last_word: rdata=%h err=%b want %h err=0", rdata, err_valid, 32'h0badf00d);
    end
  endtask

  task automatic test_out_of_range();
    acc(1, 4'h0, 32'hbfc10000, 32'h0);
    exp_rd++;
    checks++;
    if (rdata !== 32'h0 || err_valid !== 1'b1 || err_addr !== 32'hbfc10000) begin
      failures++;
      $display("FAIL oor_first: rdata=%h err=%b err_addr=%h want 0 1 %h", rdata, err_valid, err_addr, 32'hbfc10000);
    end
    acc(1, 4'h0, 32'hbfc00000, 32'h0);
    exp_rd++;
    acc(1, 4'h0, 32'h00000000, 32'h0);
    exp_rd++;
    checks++;
    if (rdata !== 32'h0 || err_valid !== 1'b1 || err_addr !== 32'hbfc10000) begin
      failures++;
      $display("FAIL oor_second: rdata=%h err=%b err_addr=%h want 0 1 %h", rdata, err_valid, err_addr, 32'hbfc10000);
    end
    acc(1, 4'hf, 32'hbfc10000, 32'hffffffff);
    exp_wr++;
    checks++;
    if (rd_cnt !== exp_rd || wr_cnt !== exp_wr || rdata !== 32'h0) begin
      failures++;
      $display("FAIL oor_counts: rd=%0d wr=%0d rdata=%h want rd=%0d wr=%0d rdata=0", rd_cnt, wr_cnt, rdata, exp_rd, exp_wr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3];
    logic [31:0] e [3];
    a[0] = 32'hbfc00000; a[1] = 32'hbfc00004; a[2] = 32'hbfc00008;
    e[0] = 32'h3c1d0000; e[1] = 32'h1122ccdd; e[2] = 32'hdeadbeef;
    for (int i = 0; i < 3; i++) begin
      acc(1, 4'h0, a[i], 32'h0);
      exp_rd++;
      checks++;
      if (rdata !== e[i]) begin
        failures++;
        $display("FAIL b2b_%0d: got %h want %h", i, rdata, e[i]);
      end
    end
    checks++;
    if (rd_cnt !== exp_rd) begin
      failures++;
      $display("FAIL b2b_count: rd=%0d want %0d", rd_cnt, exp_rd);
    end
  endtask

  task automatic test_async_reset();
    acc(1, 4'h0, 32'hbfc00008, 32'h0);
    checks++;
    if (rdata !== 32'hdeadbeef) begin
      failures++;
      $display("FAIL pre_reset_read: got %h want %h", rdata, 32'hdeadbeef);
    end
    #2;
    reset = 1;
    en = 1; wen = 4'hf; addr = 32'hbfc00000; wdata = 32'hffffffff;
    #1;
    checks++;
    if (rdata !== 32'h0 || rd_cnt !== 32'h0 || wr_cnt !== 32'h0 || err_valid !== 1'b0 || err_addr !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: rdata=%h rd=%0d wr=%0d err=%b err_addr=%h want all zero", rdata, rd_cnt, wr_cnt, err_valid, err_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdata !== 32'h0 || wr_cnt !== 32'h0) begin
      failures++;
      $display("FAIL reset_held: rdata=%h wr=%0d want 0 0", rdata, wr_cnt);
    end
    @(negedge clk);
    reset = 0;
    en = 0;
    acc(1, 4'h0, 32'hbfc00000, 32'h0);
    checks++;
    if (rdata !== 32'h3c1d0000 || rd_cnt !== 32'd1 || wr_cnt !== 32'd0) begin
      failures++;
      $display("FAIL post_reset_read0: rdata=%h rd=%0d wr=%0d want %h 1 0", rdata, rd_cnt, wr_cnt, 32'h3c1d0000);
    end
    acc(1, 4'h0, 32'hbfc00004, 32'h0);
    checks++;
    if (rdata !== 32'h1122ccdd) begin
      failures++;
      $display("FAIL post_reset_read1: got %h want %h", rdata, 32'h1122ccdd);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_byte_write();
    test_hold();
    test_boundary();
    test_out_of_range();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
